vector_sequencer: RTL and testbench
===================================

Name: vector_sequencer

Overview:
- Synthesizable, parametrised self-checking vector engine; the hardware successor of the team's simulation-only vector testbench.
- Holds a vector RAM loaded over a write port and streams stimulus into a DUT at one vector per clock.
- Compares the DUT response against expected data under a per-bit care mask, after a configurable pipeline latency.
- Reports error count, vector count, first-fail index and pass/done status; usable on FPGA for at-speed block checks.

Parameters:
- IN_W, 8, stimulus width driven to the DUT.
- OUT_W, 8, DUT response width checked.
- DEPTH, 1024, vector RAM entries; power of two.
- LATENCY, 2, clocks from stim to valid dut_out; range 1..16.
- CNT_W, 16, width of error_count and vector_count.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  write one vector entry this cycle; ignored while busy.
- load_addr  in  $clog2(DEPTH)  entry address.
- load_data  in  1+IN_W+2*OUT_W  {last, stim, expected, mask}; last=1 marks the terminator entry.
- start  in  1  one-cycle pulse that begins a run; ignored while busy.
- dut_out  in  OUT_W  DUT response.
- stim  out  IN_W  stimulus to the DUT.
- busy  out  1  run in progress.
- done  out  1  high from run completion until the next start.
- pass  out  1  done and error_count==0.
- error_count  out  CNT_W  mismatching vectors; saturates at all-ones.
- vector_count  out  CNT_W  vectors checked.
- first_fail  out  $clog2(DEPTH)  index of the first mismatch; valid when error_count!=0.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; stim, busy, done, pass, counts and first_fail are all 0; delay line cleared. RAM contents are not reset.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE + start: clear counts and first_fail, set rd_ptr=0, go to ISSUE. done drops the cycle after start.
- ISSUE:
  - Each cycle, read entry rd_ptr. The RAM is synchronous-read; stim registers one cycle after the read.
  - If last==0: drive stim, push {expected, mask, index, valid=1} into the delay line, rd_ptr++.
  - If last==1 or rd_ptr==DEPTH-1 has been issued: stop issuing and go to DRAIN. The terminator entry is never applied or counted.
- Delay line: total alignment so the delay-line output meets the dut_out produced LATENCY clocks after stim changes.
- Check (any state, when the delay-line output valid=1):
  - vector_count++.
  - Mismatch when ((dut_out ^ expected) & mask) != 0; then error_count++ (saturating).
  - On the first mismatch, capture first_fail=index.
  - mask bit 0 means that bit is don't-care.
- DRAIN: hold stim; when the delay line is empty, go to DONE. busy=0 and done=1 the same cycle. pass = (error_count==0).
- Empty table (entry 0 has last=1): DONE after the RAM latency plus the drain; vector_count=0, pass=1.
- Simultaneous load_en and start in IDLE: the write takes effect and start is honoured; a read of the same address returns the new data (write-first).
- start while busy and load_en while busy are both ignored.

Optional Feature:
- STOP_ON_FAIL_EN defined: the first mismatch forces DRAIN immediately and stops issuing. In-flight vectors are still checked and counted, and first_fail is latched.
- Undefined: the run always continues to the terminator or to DEPTH.

Decomposition:
- Package vector_sequencer_pkg: state enum (IDLE, ISSUE, DRAIN, DONE) and vector field offset/width localparams derived from IN_W/OUT_W.
- Sub-module vec_delay_line: parametrised shift register (WIDTH, STAGES) with per-stage valid bit, plus an empty output.

Test Plan:
- Loopback DUT (dut_out = stim delayed LATENCY), 4 vectors stim=01,02,03,04 with matching expected, mask=FF, terminator at index 4 -> done, vector_count=4, error_count=0, pass=1.
- Same setup with entry 2 expected=0x13 vs actual 0x03, mask=FF -> error_count=1, first_fail=2, pass=0. Repeat with mask=EF -> pass=1.
- Entry 0 terminator -> done with vector_count=0, pass=1; no stim change.
- Table with no terminator, DEPTH=16 -> vector_count=16, then done.
- Assert reset low mid-ISSUE at vector 3 -> all outputs 0 asynchronously, state IDLE. A subsequent start reruns from index 0 with correct counts.
- STOP_ON_FAIL_EN with LATENCY=2 and a mismatch at index 1 of 8 vectors -> issue stops. vector_count reflects index 1 plus in-flight vectors (≤3), error_count≥1, first_fail=1.

Source files
------------

// File: rtl/vector_sequencer_pkg.sv
// Shared types and vector-layout helpers for the vector sequencer.
// A RAM entry is packed as {last, stim, expected, mask}, with mask in the LSBs.
package vector_sequencer_pkg;

  // Sequencer run states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Field offsets inside one RAM entry
  localparam int MASK_LSB = 0;

  // Total entry width: last flag + stimulus + expected + mask
  function automatic int vec_width(input int in_w, input int out_w);
    return 1 + in_w + 2 * out_w;
  endfunction

  // LSB of the expected-response field
  function automatic int exp_lsb(input int out_w);
    return out_w;
  endfunction

  // LSB of the stimulus field
  function automatic int stim_lsb(input int out_w);
    return 2 * out_w;
  endfunction

  // Position of the terminator flag
  function automatic int last_bit(input int in_w, input int out_w);
    return 2 * out_w + in_w;
  endfunction

endpackage

// File: rtl/vec_delay_line.sv
// Fixed-length shift register carrying check payloads alongside the DUT
// pipeline. Each stage has its own valid bit; empty is high when no stage
// holds a valid payload.
module vec_delay_line #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             empty
);

  logic [WIDTH-1:0]  data_reg [STAGES];
  logic [STAGES-1:0] valid_reg;

  // Shift every stage forward by one each clock; stage 0 takes the new payload
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      valid_reg[0] <= push;
      data_reg[0]  <= data_in;
      for (int i = 1; i < STAGES; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        data_reg[i]  <= data_reg[i-1];
      end
    end
  end

  assign valid_out = valid_reg[STAGES-1];
  assign data_out  = data_reg[STAGES-1];
  assign empty     = ~|valid_reg;

endmodule

// File: rtl/vector_sequencer.sv
// Vector sequencer: streams stimulus from an on-chip vector RAM into a DUT
// at one vector per clock and checks the response under a per-bit care mask.
// Optional build macro STOP_ON_FAIL_EN: the first mismatch stops issuing and
// drains the vectors already in flight.
module vector_sequencer
  import vector_sequencer_pkg::*;
#(
  parameter int  IN_W    = 8,
  parameter int  OUT_W   = 8,
  parameter int  DEPTH   = 1024,
  parameter int  LATENCY = 2,
  parameter int  CNT_W   = 16,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int VEC_W   = vec_width(IN_W, OUT_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [VEC_W-1:0]  load_data,
  input  logic              start,
  input  logic [OUT_W-1:0]  dut_out,
  output logic [IN_W-1:0]   stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  error_count,
  output logic [CNT_W-1:0]  vector_count,
  output logic [ADDR_W-1:0] first_fail
);

  localparam int LAST_BIT  = last_bit(IN_W, OUT_W);
  localparam int STIM_LSB  = stim_lsb(OUT_W);
  localparam int EXP_LSB   = exp_lsb(OUT_W);
  localparam int DL_W      = 2 * OUT_W + ADDR_W;
  // One extra stage covers the registered stim in front of the DUT pipeline
  localparam int DL_STAGES = LATENCY + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t state_reg, state_next;

  logic [VEC_W-1:0]  ram [DEPTH];
  logic [VEC_W-1:0]  ram_q_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic              q_valid_reg;
  logic [ADDR_W-1:0] q_idx_reg;

  logic [IN_W-1:0]   stim_reg;
  logic [CNT_W-1:0]  error_count_reg;
  logic [CNT_W-1:0]  vector_count_reg;
  logic [ADDR_W-1:0] first_fail_reg;

  logic              rd_en;
  logic              apply;
  logic              clear_run;
  logic              stop_now;

  logic              q_last;
  logic [IN_W-1:0]   q_stim;
  logic [OUT_W-1:0]  q_exp;
  logic [OUT_W-1:0]  q_mask;

  logic              dl_valid;
  logic [DL_W-1:0]   dl_data;
  logic              dl_empty;
  logic [OUT_W-1:0]  dl_exp;
  logic [OUT_W-1:0]  dl_mask;
  logic [ADDR_W-1:0] dl_idx;
  logic              chk_fail;

  assign q_last = ram_q_reg[LAST_BIT];
  assign q_stim = ram_q_reg[STIM_LSB +: IN_W];
  assign q_exp  = ram_q_reg[EXP_LSB +: OUT_W];
  assign q_mask = ram_q_reg[MASK_LSB +: OUT_W];

  assign dl_exp  = dl_data[ADDR_W + OUT_W +: OUT_W];
  assign dl_mask = dl_data[ADDR_W +: OUT_W];
  assign dl_idx  = dl_data[ADDR_W-1:0];

  assign chk_fail = dl_valid && (|((dut_out ^ dl_exp) & dl_mask));

`ifdef STOP_ON_FAIL_EN
  assign stop_now = chk_fail;
`else
  assign stop_now = 1'b0;
`endif

  // Vector RAM: writes only outside a run and reads only during ISSUE, so a
  // start coinciding with a load always sees the freshly written entry.
  always_ff @(posedge clock) begin
    if (load_en && !busy) begin
      ram[load_addr] <= load_data;
    end
    if (rd_en) begin
      ram_q_reg <= ram[rd_ptr_reg];
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control decode; reads run one ahead of the entry being
  // evaluated, and any read still in flight when issuing stops is discarded
  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    apply      = 1'b0;
    clear_run  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          clear_run  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (stop_now) begin
          state_next = DRAIN;
        end else if (q_valid_reg) begin
          if (q_last) begin
            state_next = DRAIN;
          end else begin
            apply = 1'b1;
            if (q_idx_reg == LAST_ADDR) begin
              state_next = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (dl_empty) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          clear_run  = 1'b1;
          state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read pointer and read-stage bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg  <= '0;
      q_valid_reg <= 1'b0;
      q_idx_reg   <= '0;
    end else begin
      q_valid_reg <= rd_en;
      q_idx_reg   <= rd_ptr_reg;
      if (clear_run) begin
        rd_ptr_reg <= '0;
      end else if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Stimulus register; held between vectors and through DRAIN/DONE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stim_reg <= '0;
    end else if (apply) begin
      stim_reg <= q_stim;
    end
  end

  // Result counters and first-failure capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error_count_reg  <= '0;
      vector_count_reg <= '0;
      first_fail_reg   <= '0;
    end else if (clear_run) begin
      error_count_reg  <= '0;
      vector_count_reg <= '0;
      first_fail_reg   <= '0;
    end else if (dl_valid) begin
      vector_count_reg <= vector_count_reg + CNT_W'(1);
      if (chk_fail) begin
        if (error_count_reg == '0) begin
          first_fail_reg <= dl_idx;
        end
        if (error_count_reg != CNT_MAX) begin
          error_count_reg <= error_count_reg + CNT_W'(1);
        end
      end
    end
  end

  vec_delay_line #(
    .WIDTH  (DL_W),
    .STAGES (DL_STAGES)
  ) u_delay (
    .clock     (clock),
    .reset     (reset),
    .push      (apply),
    .data_in   ({q_exp, q_mask, q_idx_reg}),
    .valid_out (dl_valid),
    .data_out  (dl_data),
    .empty     (dl_empty)
  );

  assign stim         = stim_reg;
  assign pass         = done && (error_count_reg == '0);
  assign error_count  = error_count_reg;
  assign vector_count = vector_count_reg;
  assign first_fail   = first_fail_reg;

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench for vector_sequencer with a loopback DUT model
// (dut_out = stim delayed LATENCY clocks). Expected run results are queued
// when a run starts and checked by a monitor when done rises.
module tb_vector_sequencer;

  localparam int IN_W    = 8;
  localparam int OUT_W   = 8;
  localparam int DEPTH   = 16;
  localparam int LATENCY = 2;
  localparam int CNT_W   = 16;
  localparam int ADDR_W  = 4;
  localparam int VEC_W   = 1 + IN_W + 2 * OUT_W;

  typedef struct {
    logic [CNT_W-1:0]  vc;
    logic [CNT_W-1:0]  ec;
    logic [ADDR_W-1:0] ff;
    logic              pass;
    logic [IN_W-1:0]   stim;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [VEC_W-1:0]  load_data = '0;
  logic              start = 1'b0;
  logic [OUT_W-1:0]  dut_out;
  logic [IN_W-1:0]   stim;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  error_count, vector_count;
  logic [ADDR_W-1:0] first_fail;

  int   compared   = 0;
  int   mismatched = 0;
  int   run_no     = 0;
  exp_t sb_q[$];
  logic mon_done_prev = 1'b0;
  exp_t res_t5;

  vector_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LATENCY(LATENCY), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .dut_out(dut_out), .stim(stim),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .vector_count(vector_count), .first_fail(first_fail)
  );

  always #5 clock = ~clock;

  // Loopback DUT: LATENCY-stage register chain
  logic [OUT_W-1:0] pipe [LATENCY];
  always @(posedge clock) begin
    pipe[0] <= stim;
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign dut_out = pipe[LATENCY-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got event, required none", name);
  endtask

  // Monitor: one scoreboard entry per run completion
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done && !mon_done_prev) begin
        run_no++;
        $display("run %0d: vector_count=%0d error_count=%0d first_fail=%0d pass=%0b stim=%h",
                 run_no, vector_count, error_count, first_fail, pass, stim);
        if (sb_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = sb_q.pop_front();
          check("vector_count", 32'(vector_count), 32'(e.vc));
          check("error_count",  32'(error_count),  32'(e.ec));
          check("first_fail",   32'(first_fail),   32'(e.ff));
          check("pass",         32'(pass),         32'(e.pass));
          check("stim_final",   32'(stim),         32'(e.stim));
        end
      end
      mon_done_prev = done;
    end
  end

  task automatic load_entry(input int addr, input logic last, input logic [7:0] s,
                            input logic [7:0] e, input logic [7:0] m);
    @(negedge clock);
    load_en   = 1'b1;
    load_addr = ADDR_W'(addr);
    load_data = {last, s, e, m};
    @(negedge clock);
    load_en   = 1'b0;
  endtask

  task automatic start_run(input exp_t e);
    sb_q.push_back(e);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!done) fail_now({name, "_timeout"});
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stim"},         32'(stim),         0);
    check({tag, "_busy"},         32'(busy),         0);
    check({tag, "_done"},         32'(done),         0);
    check({tag, "_pass"},         32'(pass),         0);
    check({tag, "_error_count"},  32'(error_count),  0);
    check({tag, "_vector_count"}, 32'(vector_count), 0);
    check({tag, "_first_fail"},   32'(first_fail),   0);
  endtask

  initial begin
    int n;
    #1 reset = 1'b0;
    #2 check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // T1: four matching vectors, terminator at 4
    for (int i = 0; i < 4; i++) load_entry(i, 1'b0, 8'(i + 1), 8'(i + 1), 8'hFF);
    load_entry(4, 1'b1, 8'h00, 8'h00, 8'h00);
    start_run('{vc: 4, ec: 0, ff: 0, pass: 1'b1, stim: 8'h04});
    wait_done("t1");

    // T2: entry 2 expects 0x13 but loopback gives 0x03
    load_entry(2, 1'b0, 8'h03, 8'h13, 8'hFF);
    start_run('{vc: 4, ec: 1, ff: 2, pass: 1'b0, stim: 8'h04});
    wait_done("t2");

    // T3: same, differing bit masked off
    load_entry(2, 1'b0, 8'h03, 8'h13, 8'hEF);
    start_run('{vc: 4, ec: 0, ff: 0, pass: 1'b1, stim: 8'h04});
    wait_done("t3");

    // T4: terminator written to entry 0 in the same cycle as start
    sb_q.push_back('{vc: 0, ec: 0, ff: 0, pass: 1'b1, stim: 8'h04});
    @(negedge clock);
    load_en = 1'b1; load_addr = '0; load_data = {1'b1, 24'h0}; start = 1'b1;
    @(negedge clock);
    load_en = 1'b0; start = 1'b0;
    wait_done("t4");

    // T5: full table without terminator, mismatches at 5 and 9
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] s;
      s = 8'(8'h10 + i);
      load_entry(i, 1'b0, s, (i == 5) ? 8'h00 : (i == 9) ? (s ^ 8'h80) : s, 8'hFF);
    end
`ifdef STOP_ON_FAIL_EN
    res_t5 = '{vc: 8, ec: 1, ff: 5, pass: 1'b0, stim: 8'h17};
`else
    res_t5 = '{vc: 16, ec: 2, ff: 5, pass: 1'b0, stim: 8'h1F};
`endif
    start_run(res_t5);
    // start and load while busy must both be ignored
    @(negedge clock);
    load_en = 1'b1; load_addr = 4'd3; load_data = {1'b0, 8'h13, 8'hAA, 8'hFF}; start = 1'b1;
    @(negedge clock);
    load_en = 1'b0; start = 1'b0;
    wait_done("t5");

    // T6: rerun proves entry 3 was not overwritten
    start_run(res_t5);
    wait_done("t6");

    // T7: asynchronous reset while vector 3 is on stim
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (stim != 8'h13 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (stim != 8'h13) fail_now("t7_stim_timeout");
    #2 reset = 1'b0;
    #1 check_all_zero("midrun_reset");
    @(negedge clock);
    reset = 1'b1;
    start_run(res_t5);
    wait_done("t7");

    // T8: eight vectors, mismatch at index 1, terminator at 8
    for (int i = 0; i < 8; i++)
      load_entry(i, 1'b0, 8'(8'h20 + i), (i == 1) ? 8'h20 : 8'(8'h20 + i), 8'hFF);
    load_entry(8, 1'b1, 8'h00, 8'h00, 8'h00);
`ifdef STOP_ON_FAIL_EN
    start_run('{vc: 4, ec: 1, ff: 1, pass: 1'b0, stim: 8'h23});
`else
    start_run('{vc: 8, ec: 1, ff: 1, pass: 1'b0, stim: 8'h27});
`endif
    wait_done("t8");

    repeat (3) @(negedge clock);
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_leftover: got %0d pending, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
